// File: rtl/fp16_sqrt_iter_pkg.sv
// Shared FP16 unpacked-operand types and constants for the unpack / sqrt / pack stages.
// Pure declarations; no latency or flow control of its own.
package fp16_pkg;

  localparam int FP16_BIAS  = 15;
  localparam int EXP_ZERO   = -15;
  localparam int CALC_STEPS = 11;
  localparam int FP_MANT_W  = 11;
  localparam int FP_EXP_W   = 7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SPEC = 2'd1,
    CALC = 2'd2,
    DONE = 2'd3
  } sqrt_state_t;

  typedef struct packed {
    logic                       sign;
    logic signed [FP_EXP_W-1:0] exp;
    logic [FP_MANT_W-1:0]       mant;
    logic                       is_nan;
    logic                       is_pinf;
    logic                       is_ninf;
  } fp16_unpacked_t;

  // Zero uses the same encoding as pack: minimum exponent with an empty mantissa.
  function automatic logic is_zero(input fp16_unpacked_t op);
    return (op.exp == FP_EXP_W'(EXP_ZERO)) && (op.mant == '0);
  endfunction

endpackage

// File: rtl/fp16_sqrt_iter_if.sv
// Operand/result bundle between unpack, the sqrt core and pack.
// master = upstream/testbench side, slave = sqrt core; result side has no backpressure.
interface fp16_sqrt_iter_if #(
  parameter int MANT_W = 11,
  parameter int EXP_W  = 7
);

  logic                    u_valid;
  logic                    u_ready;
  logic                    sign_in;
  logic signed [EXP_W-1:0] exp_in;
  logic [MANT_W-1:0]       mant_in;
  logic                    is_nan_in;
  logic                    is_pinf_in;
  logic                    is_ninf_in;

  logic                    it_valid;
  logic                    sign_out;
  logic signed [EXP_W-1:0] exp_out;
  logic [MANT_W-1:0]       mant_out;
  logic                    is_nan_out;
  logic                    is_pinf_out;
  logic                    is_ninf_out;
  logic                    result_out;

  modport master (
    output u_valid, sign_in, exp_in, mant_in, is_nan_in, is_pinf_in, is_ninf_in,
    input  u_ready, it_valid, sign_out, exp_out, mant_out,
           is_nan_out, is_pinf_out, is_ninf_out, result_out
  );

  modport slave (
    input  u_valid, sign_in, exp_in, mant_in, is_nan_in, is_pinf_in, is_ninf_in,
    output u_ready, it_valid, sign_out, exp_out, mant_out,
           is_nan_out, is_pinf_out, is_ninf_out, result_out
  );

endinterface

// File: rtl/fp16_sqrt_iter_step.sv
// One restoring square-root iteration: bring down two radicand bits, trial-subtract {q, 01}.
// Purely combinational; the caller registers remainder and quotient.
module sqrt_step #(
  parameter int MANT_W = 11
) (
  input  logic [MANT_W-1:0] i_rem,
  input  logic [MANT_W-1:0] i_q,
  input  logic [1:0]        i_bits,
  output logic [MANT_W+1:0] o_rem,
  output logic              o_q_bit
);

  logic [MANT_W+1:0] w_shifted;
  logic [MANT_W+1:0] w_trial;

  assign w_shifted = {i_rem, i_bits};
  assign w_trial   = {i_q, 2'b01};
  assign o_q_bit   = (w_shifted >= w_trial);
  assign o_rem     = o_q_bit ? (w_shifted - w_trial) : w_shifted;

endmodule

// File: rtl/fp16_sqrt_iter.sv
// Iterative FP16 square root, one quotient bit per cycle; 2-cycle specials, 12-cycle normals.
// u_ready only in IDLE; it_valid is a single-cycle strobe that is never stalled.
module fp16_sqrt_iter
  import fp16_pkg::*;
#(
  parameter int MANT_W = 11,
  parameter int EXP_W  = 7
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           enable,
  fp16_sqrt_iter_if.slave u_if
);

  localparam int RAD_W = 2 * MANT_W;
  localparam int CNT_W = $clog2(CALC_STEPS);

  sqrt_state_t       r_state;
  sqrt_state_t       w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  fp16_unpacked_t    r_op;
  fp16_unpacked_t    w_op_in;
  logic [RAD_W-1:0]  r_rad;
  logic [MANT_W-1:0] r_rem;
  logic [MANT_W-1:0] r_q;

  logic                    r_sign;
  logic signed [EXP_W-1:0] r_exp;
  logic [MANT_W-1:0]       r_mant;
  logic                    r_nan;
  logic                    r_pinf;
  logic                    r_ninf;
  logic                    r_inx;

  logic              w_ready;
  logic              w_it_valid;
  logic              w_accept;
  logic              w_special;
  logic              w_op_zero;
  logic              w_res_nan;
  logic              w_res_pinf;
  logic              w_res_zero;
  logic [MANT_W+1:0] w_rem_nxt;
  logic              w_q_bit;

  assign w_op_in = '{sign: u_if.sign_in, exp: u_if.exp_in, mant: u_if.mant_in,
                     is_nan: u_if.is_nan_in, is_pinf: u_if.is_pinf_in,
                     is_ninf: u_if.is_ninf_in};

  assign w_accept  = u_if.u_valid & w_ready;
  // Any sign bit set goes to SPEC: -0 stays signed zero, other negatives become NaN.
  assign w_special = w_op_in.is_nan | w_op_in.is_pinf | w_op_in.is_ninf |
                     w_op_in.sign | is_zero(w_op_in);

  assign w_op_zero  = is_zero(r_op);
  assign w_res_nan  = r_op.is_nan | r_op.is_ninf | (r_op.sign & ~r_op.is_pinf & ~w_op_zero);
  assign w_res_pinf = ~w_res_nan & r_op.is_pinf;
  assign w_res_zero = ~w_res_nan & ~w_res_pinf & w_op_zero;

  sqrt_step #(.MANT_W(MANT_W)) u_step (
    .i_rem   (r_rem),
    .i_q     (r_q),
    .i_bits  (r_rad[RAD_W-1:RAD_W-2]),
    .o_rem   (w_rem_nxt),
    .o_q_bit (w_q_bit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (!enable) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE:    if (w_accept) w_state_nxt = w_special ? SPEC : CALC;
        SPEC:    w_state_nxt = DONE;
        CALC:    if (r_cnt == '0) w_state_nxt = DONE;
        DONE:    w_state_nxt = IDLE;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    w_ready    = 1'b0;
    w_it_valid = 1'b0;
    case (r_state)
      IDLE:    w_ready    = enable;
      DONE:    w_it_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_op   <= '0;
      r_rad  <= '0;
      r_rem  <= '0;
      r_q    <= '0;
      r_sign <= 1'b0;
      r_exp  <= '0;
      r_mant <= '0;
      r_nan  <= 1'b0;
      r_pinf <= 1'b0;
      r_ninf <= 1'b0;
      r_inx  <= 1'b0;
    end else if (!enable) begin
      r_cnt  <= '0;
      r_sign <= 1'b0;
      r_exp  <= '0;
      r_mant <= '0;
      r_nan  <= 1'b0;
      r_pinf <= 1'b0;
      r_ninf <= 1'b0;
      r_inx  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_op  <= w_op_in;
            r_cnt <= CNT_W'(CALC_STEPS - 1);
            r_rem <= '0;
            r_q   <= '0;
            // Odd exponents donate one factor of two to the radicand so the exponent halves exactly.
            r_rad <= u_if.exp_in[0] ? {u_if.mant_in, {MANT_W{1'b0}}}
                                    : {1'b0, u_if.mant_in, {(MANT_W-1){1'b0}}};
          end
        end
        SPEC: begin
          r_sign <= w_res_zero & r_op.sign;
          r_exp  <= w_res_zero ? EXP_W'(EXP_ZERO) : '0;
          r_mant <= '0;
          r_nan  <= w_res_nan;
          r_pinf <= w_res_pinf;
          r_ninf <= 1'b0;
          r_inx  <= 1'b0;
        end
        CALC: begin
          r_rem <= w_rem_nxt[MANT_W-1:0];
          r_q   <= {r_q[MANT_W-2:0], w_q_bit};
          r_rad <= {r_rad[RAD_W-3:0], 2'b00};
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
          end else begin
            r_sign <= 1'b0;
            r_exp  <= $signed(r_op.exp) >>> 1;
            r_mant <= {r_q[MANT_W-2:0], w_q_bit};
            r_nan  <= 1'b0;
            r_pinf <= 1'b0;
            r_ninf <= 1'b0;
            r_inx  <= (w_rem_nxt != '0);
          end
        end
        default: ;
      endcase
    end
  end

  assign u_if.u_ready     = w_ready;
  assign u_if.it_valid    = w_it_valid;
  assign u_if.sign_out    = r_sign;
  assign u_if.exp_out     = r_exp;
  assign u_if.mant_out    = r_mant;
  assign u_if.is_nan_out  = r_nan;
  assign u_if.is_pinf_out = r_pinf;
  assign u_if.is_ninf_out = r_ninf;
  assign u_if.result_out  = r_inx;

endmodule

// File: tb/tb_fp16_sqrt_iter.sv
// Testbench for fp16_sqrt_iter: directed corner cases, aborts, busy-hold and random operands
// compared against an arithmetic square-root reference.
module tb_fp16_sqrt_iter;

  logic clk = 1'b0;
  logic rst_n;
  logic enable;

  always #5 clk = ~clk;

  fp16_sqrt_iter_if #(.MANT_W(11), .EXP_W(7)) u_if ();

  fp16_sqrt_iter #(.MANT_W(11), .EXP_W(7)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (enable),
    .u_if   (u_if)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  // {sign, exp[6:0], mant[10:0], nan, pinf, ninf, inexact}
  function automatic logic [22:0] dut_res();
    return {u_if.sign_out, u_if.exp_out, u_if.mant_out,
            u_if.is_nan_out, u_if.is_pinf_out, u_if.is_ninf_out, u_if.result_out};
  endfunction

  function automatic logic is_special(input logic s, input int e, input int m,
                                      input logic nan, input logic pinf, input logic ninf);
    return nan || pinf || ninf || s || (e == -15 && m == 0);
  endfunction

  function automatic logic [22:0] model(input logic s, input int e, input int m,
                                        input logic nan, input logic pinf, input logic ninf);
    logic   zero;
    int     eo;
    longint n;
    longint r;
    logic [6:0]  eo7;
    logic [10:0] r11;
    zero = (e == -15) && (m == 0);
    if (nan)  return {1'b0, 7'd0, 11'd0, 4'b1000};
    if (ninf) return {1'b0, 7'd0, 11'd0, 4'b1000};
    if (pinf) return {1'b0, 7'd0, 11'd0, 4'b0100};
    if (zero) begin
      eo7 = 7'(-15);
      return {s, eo7, 11'd0, 4'b0000};
    end
    if (s) return {1'b0, 7'd0, 11'd0, 4'b1000};
    eo = (e >= 0) ? (e / 2) : -((-e + 1) / 2);
    n  = ((e % 2) != 0) ? longint'(m) * 2048 : longint'(m) * 1024;
    r  = longint'($floor($sqrt(real'(n))));
    while (r * r > n) r--;
    while ((r + 1) * (r + 1) <= n) r++;
    eo7 = 7'(eo);
    r11 = 11'(r);
    return {1'b0, eo7, r11, 3'b000, (r * r != n)};
  endfunction

  task automatic drive_operand(input logic s, input int e, input int m,
                               input logic nan, input logic pinf, input logic ninf);
    u_if.sign_in    = s;
    u_if.exp_in     = 7'(e);
    u_if.mant_in    = 11'(m);
    u_if.is_nan_in  = nan;
    u_if.is_pinf_in = pinf;
    u_if.is_ninf_in = ninf;
    u_if.u_valid    = 1'b1;
  endtask

  task automatic scramble_inputs();
    u_if.u_valid    = 1'b0;
    u_if.sign_in    = 1'($urandom);
    u_if.exp_in     = 7'($urandom);
    u_if.mant_in    = 11'($urandom);
    u_if.is_nan_in  = 1'($urandom);
    u_if.is_pinf_in = 1'($urandom);
    u_if.is_ninf_in = 1'($urandom);
  endtask

  // Called and returns on a falling edge.
  task automatic do_op(input logic s, input int e, input int m,
                       input logic nan, input logic pinf, input logic ninf);
    logic [22:0] expv;
    int          lat;
    int          exp_lat;
    bit          seen;
    expv    = model(s, e, m, nan, pinf, ninf);
    exp_lat = is_special(s, e, m, nan, pinf, ninf) ? 2 : 12;
    lat = 0;
    while (!u_if.u_ready && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("ready", u_if.u_ready, 1);
    drive_operand(s, e, m, nan, pinf, ninf);
    @(posedge clk);
    #1;
    scramble_inputs();
    lat  = 0;
    seen = 0;
    while (!seen && lat < 40) begin
      @(negedge clk);
      lat++;
      if (u_if.it_valid) seen = 1;
    end
    check("latency", lat, exp_lat);
    check("result", dut_res(), expv);
    @(negedge clk);
    check("strobe_end", {u_if.it_valid, u_if.u_ready}, 2'b01);
  endtask

  task automatic count_pulses(input int cycles, output int pulses);
    pulses = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (u_if.it_valid) pulses++;
    end
  endtask

  initial begin
    int pulses;
    int accepts;
    logic s;
    int e;
    int m;
    logic [2:0] fl;

    rst_n  = 1'b0;
    enable = 1'b1;
    scramble_inputs();
    #12;
    check("rst_res", dut_res(), 0);
    check("rst_vld_rdy", {u_if.it_valid, u_if.u_ready}, 2'b01);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    do_op(0,   2, 'h400, 0, 0, 0);
    do_op(0,   1, 'h400, 0, 0, 0);
    do_op(0,  -2, 'h400, 0, 0, 0);
    do_op(0, -24, 'h400, 0, 0, 0);
    do_op(1,   0, 'h400, 0, 0, 0);
    do_op(0,  16, 0,     0, 1, 0);
    do_op(1, -15, 0,     0, 0, 0);
    do_op(1,  16, 'h200, 1, 0, 0);
    do_op(0,  16, 0,     0, 1, 1);
    do_op(1, -15, 0,     0, 1, 0);
    do_op(0,  15, 'h7FF, 0, 0, 0);

    // Soft-clear abort mid-CALC
    do_op(0, 2, 'h400, 0, 0, 0);
    drive_operand(0, 7, 'h5A5, 0, 0, 0);
    @(posedge clk);
    #1;
    scramble_inputs();
    repeat (5) @(negedge clk);
    enable = 1'b0;
    @(posedge clk);
    #1;
    check("en_clr_res", dut_res(), 0);
    check("en_clr_vld", u_if.it_valid, 0);
    @(negedge clk);
    enable = 1'b1;
    @(negedge clk);
    check("en_ready", u_if.u_ready, 1);
    count_pulses(20, pulses);
    check("en_no_strobe", pulses, 0);

    // Asynchronous reset mid-CALC
    do_op(0, 1, 'h400, 0, 0, 0);
    drive_operand(0, -7, 'h6B3, 0, 0, 0);
    @(posedge clk);
    #1;
    scramble_inputs();
    repeat (5) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("arst_res", dut_res(), 0);
    check("arst_vld", u_if.it_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("arst_ready", u_if.u_ready, 1);
    count_pulses(20, pulses);
    check("arst_no_strobe", pulses, 0);

    // u_valid held through busy periods: one result per accept
    accepts = 0;
    pulses  = 0;
    drive_operand(0, 3, 'h4C1, 0, 0, 0);
    for (int i = 0; i < 39; i++) begin
      if (u_if.u_ready) accepts++;
      if (u_if.it_valid) pulses++;
      @(negedge clk);
    end
    u_if.u_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (u_if.it_valid) pulses++;
      @(negedge clk);
    end
    check("busy_accepts", accepts, 3);
    check("busy_strobes", pulses, 3);
    check("busy_result", dut_res(), model(0, 3, 'h4C1, 0, 0, 0));

    for (int k = 0; k < 40; k++) begin
      s  = ($urandom_range(0, 7) == 0);
      e  = int'($urandom_range(0, 39)) - 24;
      m  = 'h400 | int'($urandom_range(0, 1023));
      fl = 3'b000;
      case ($urandom_range(0, 9))
        0: begin e = -15; m = 0; end
        1: fl = 3'($urandom_range(1, 7));
        default: ;
      endcase
      do_op(s, e, m, fl[2], fl[1], fl[0]);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fp16_sqrt_iter.md
# fp16_sqrt_iter

Iterative FP16 square-root core sitting directly upstream of the `pack` stage. It accepts an unpacked operand (sign, unbiased signed exponent, 11-bit mantissa with hidden bit, special-case flags) and runs a restoring digit-by-digit square root, one result bit per cycle. It emits an unpacked result plus flags with a one-cycle `it_valid` pulse that `pack` consumes directly.

## Interface
- `MANT_W`, default 11: mantissa width including hidden bit.
- `EXP_W`, default 7: signed unbiased exponent width.
- `clk`  in  1  clock; all state updates on rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `enable`  in  1  synchronous soft clear; low forces IDLE and zeroes outputs.
- `u_valid`  in  1  operand valid from unpack stage.
- `u_ready`  out  1  high only in IDLE; an operand is accepted on `u_valid && u_ready`.
- `sign_in`  in  1  operand sign.
- `exp_in`  in  7  signed unbiased exponent, range −24..15; subnormals arrive pre-normalized.
- `mant_in`  in  11  mantissa, bit 10 set for every nonzero finite operand.
- `is_nan_in`, `is_pinf_in`, `is_ninf_in`  in  1 each  special-case flags.
- `it_valid`  out  1  one-cycle result strobe to `pack`.
- `sign_out`  out  1  result sign.
- `exp_out`  out  7  signed unbiased result exponent.
- `mant_out`  out  11  result mantissa.
- `is_nan_out`, `is_pinf_out`, `is_ninf_out`  out  1 each  result flags.
- `result_out`  out  1  inexact flag: final remainder nonzero.

## Operation
- Zero encoding: `exp == −15 && mant == 0`, matching `pack`.
- Classification at accept, in priority order:
  - NaN in → NaN out.
  - −inf, or negative nonzero finite → NaN out.
  - +inf → +inf out.
  - ±0 → same-signed zero (exp −15, mant 0).
  - Otherwise: normal path.
- Special results: `sign_out` 0 except on the signed-zero case; `result_out` 0; `exp_out`/`mant_out` 0 for NaN and inf.
- Normal path:
  - `exp_out = exp_in >>> 1` (arithmetic shift, floor).
  - Radicand (22 bits) = `{1'b0, mant_in, 10'b0}` if `exp_in` is even, `{mant_in, 11'b0}` if odd.
  - Restoring sqrt over 11 iterations, MSB first. Each iteration brings down two radicand bits into a 13-bit partial remainder and trial-subtracts `{q, 2'b01}`.
  - `mant_out = q`; bit 10 is always 1. Truncating, no rounding.
  - `result_out = (remainder != 0)`; `sign_out` 0.
  - Result exponent stays within −12..7, so output is never subnormal.
- FSM states:
  - IDLE: on accept, go to SPEC for specials, else CALC with counter = 10.
  - SPEC: load special result, go to DONE.
  - CALC: one iteration per cycle; when counter reaches 0, go to DONE.
  - DONE: assert `it_valid` for one cycle, return to IDLE.
- Outputs hold their last values between strobes. `pack` has no backpressure, so `it_valid` is never stalled.

## Timing
- Reset (async, `rst_n` low), or `enable` low at a clock edge:
  - State IDLE, counter 0.
  - `u_ready` goes to 1 once `enable` is high.
  - `it_valid`, all flags, `sign_out`, `exp_out`, `mant_out`, `result_out` = 0.
- Latency from accept edge to `it_valid` high:
  - Specials: 2 cycles (SPEC, then DONE).
  - Normal: 12 cycles (11 CALC, then DONE).
- Throughput: one operation per 3 cycles (specials) or 13 cycles (normal). `u_ready` rises in the cycle after DONE.
- `u_valid` while busy is ignored. The operand is captured only at the accept edge, so input changes afterwards have no effect.
- Reset or `enable` low mid-CALC aborts the operation; no `it_valid` is produced for it.
- Multiple flags set at once are resolved by the priority order in Operation.

## Structure
- Shared package `fp16_pkg`:
  - `FP16_BIAS` = 15.
  - `EXP_ZERO` = −15.
  - `CALC_STEPS` = 11.
  - The state enum (IDLE, SPEC, CALC, DONE).
  - The unpacked-operand struct, shared with the unpack stage and `pack`.
- One natural sub-module: `sqrt_step`, a combinational single-iteration trial subtract taking remainder, quotient and next two radicand bits, returning the new remainder and quotient bit.

## Test plan
- 4.0 (exp 2, mant 0x400) → after 12 cycles `it_valid`; exp 1, mant 0x400, `result_out` 0.
- 2.0 (exp 1, mant 0x400) → exp 0, mant 0x5A8, `result_out` 1.
- 0.25 (exp −2, mant 0x400) → exp −1, mant 0x400.
- Min subnormal 2^−24 (exp −24, mant 0x400) → exp −12, mant 0x400.
- −1.0 → NaN flag after 2 cycles.
- +inf → `is_pinf_out`.
- −0 → sign 1, exp −15, mant 0.
- NaN with `sign_in` 1 → NaN only.
- `enable` dropped at CALC cycle 5 → no `it_valid`, outputs zero, `u_ready` high after re-enable.
- `rst_n` asserted asynchronously mid-CALC → same as above.
- `u_valid` held during busy → exactly one result per accept.
